pipeline_hazard_ctrl: RTL and testbench

Central stall/flush controller for the 5-stage RV32I pipeline. It sits beside the forwarding unit and decides when the pipeline registers update, hold or turn into bubbles. It resolves three cases:
- load-use hazards that forwarding cannot cover;
- taken-branch redirects;
- multi-cycle data-memory waits, with a timeout error state.

It also keeps saturating performance counters for stalls and flushes.

---
 rtl/rv32_pipe_pkg.sv | 11 +
 rtl/load_use_detect.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 95 +++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pipe_pkg.sv
// rv32_pipe_pkg: shared pipeline-control types and constants.
//   pipeState_t : hazard controller FSM state encoding
//   REG_X0      : architectural zero register index
package rv32_pipe_pkg;
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } pipeState_t;
    localparam logic [4:0] REG_X0 = 5'd0;
endpackage

// File: rtl/load_use_detect.sv
// load_use_detect: combinational load-use hazard detection.
//   in  idex_MemRead, idex_writeRegister    : load in EX and its rd
//   in  ifid_readRegister1/2, ifid_usesRs1/2 : ID sources and whether they are read
//   in  ifid_isStore                         : ID instruction is a store
//   out loadUse                              : stall needed
module load_use_detect
    import rv32_pipe_pkg::*;
(
    input  logic       idex_MemRead,
    input  logic [4:0] idex_writeRegister,
    input  logic [4:0] ifid_readRegister1,
    input  logic [4:0] ifid_readRegister2,
    input  logic       ifid_usesRs1,
    input  logic       ifid_usesRs2,
    input  logic       ifid_isStore,
    output logic       loadUse
);
    logic m1, m2;
    assign m1 = ifid_usesRs1 && (ifid_readRegister1 == idex_writeRegister);
    assign m2 = ifid_usesRs2 && (ifid_readRegister2 == idex_writeRegister);
    // store data on rs2 is covered by load-to-store forwarding
    assign loadUse = idex_MemRead && (idex_writeRegister != REG_X0) && (m1 || (m2 && !ifid_isStore));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush controller for the 5-stage pipeline.
//   in  clk, rst_n (async, active-low)
//   in  idex_*, ifid_*       : hazard inputs from EX and ID
//   in  ex_branchTaken       : redirect from EX
//   in  exmem_memAccess, dmem_ready : data-memory handshake
//   out pc_write, ifid_write, idex_write, exmem_write : register enables
//   out ifid_flush, idex_flush, memwb_bubble           : bubble inserts
//   out mem_timeout          : sticky data-memory timeout flag
//   out stall_cycles, flush_count : saturating performance counters
module pipeline_hazard_ctrl
    import rv32_pipe_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_writeRegister,
    input  logic [4:0]       ifid_readRegister1,
    input  logic [4:0]       ifid_readRegister2,
    input  logic             ifid_usesRs1,
    input  logic             ifid_usesRs2,
    input  logic             ifid_isStore,
    input  logic             ex_branchTaken,
    input  logic             exmem_memAccess,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             memwb_bubble,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);
    localparam int CW = $clog2(TIMEOUT + 2);

    pipeState_t state, nextState;
    logic [CW-1:0] waitCnt, waitNext;
    logic loadUse, mw, active, doWait, doFlush, doStall;

    load_use_detect luDetect (
        .idex_MemRead       (idex_MemRead),
        .idex_writeRegister (idex_writeRegister),
        .ifid_readRegister1 (ifid_readRegister1),
        .ifid_readRegister2 (ifid_readRegister2),
        .ifid_usesRs1       (ifid_usesRs1),
        .ifid_usesRs2       (ifid_usesRs2),
        .ifid_isStore       (ifid_isStore),
        .loadUse            (loadUse)
    );

    assign mw      = exmem_memAccess && !dmem_ready;
    // reset forces every control output low
    assign active  = rst_n && (state != ERROR);
    assign doWait  = active && mw;
    assign doFlush = active && !mw && ex_branchTaken;
    assign doStall = active && !mw && !ex_branchTaken && loadUse;

    assign pc_write     = active && !mw && !doStall;
    assign ifid_write   = pc_write;
    assign idex_write   = active && !mw;
    assign exmem_write  = idex_write;
    assign ifid_flush   = doFlush;
    assign idex_flush   = doFlush || doStall;
    assign memwb_bubble = doWait;

    // the RUN cycle that first sees mw counts as wait cycle one
    assign waitNext = ((state == MEM_WAIT) ? waitCnt : CW'(0)) + CW'(1);

    always_comb begin
        nextState = state;
        if (state != ERROR)
            nextState = !mw ? RUN : (waitNext >= CW'(TIMEOUT)) ? ERROR : MEM_WAIT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= RUN;
            waitCnt      <= '0;
            mem_timeout  <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state        <= nextState;
            waitCnt      <= (mw && state != ERROR) ? waitNext : '0;
            mem_timeout  <= mem_timeout || (nextState == ERROR);
            stall_cycles <= ((doWait || doStall) && !(&stall_cycles)) ? stall_cycles + 1'b1 : stall_cycles;
            flush_count  <= (doFlush && !(&flush_count)) ? flush_count + 1'b1 : flush_count;
        end
    end
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed self-checking bench (TIMEOUT=4, CNT_W=2).
module tb_pipeline_hazard_ctrl;
    logic clk = 1'b0;
    logic rst_n;
    logic idex_MemRead;
    logic [4:0] idex_writeRegister, ifid_readRegister1, ifid_readRegister2;
    logic ifid_usesRs1, ifid_usesRs2, ifid_isStore;
    logic ex_branchTaken, exmem_memAccess, dmem_ready;
    logic pc_write, ifid_write, idex_write, exmem_write;
    logic ifid_flush, idex_flush, memwb_bubble, mem_timeout;
    logic [1:0] stall_cycles, flush_count;
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.TIMEOUT(4), .CNT_W(2)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .idex_MemRead       (idex_MemRead),
        .idex_writeRegister (idex_writeRegister),
        .ifid_readRegister1 (ifid_readRegister1),
        .ifid_readRegister2 (ifid_readRegister2),
        .ifid_usesRs1       (ifid_usesRs1),
        .ifid_usesRs2       (ifid_usesRs2),
        .ifid_isStore       (ifid_isStore),
        .ex_branchTaken     (ex_branchTaken),
        .exmem_memAccess    (exmem_memAccess),
        .dmem_ready         (dmem_ready),
        .pc_write           (pc_write),
        .ifid_write         (ifid_write),
        .idex_write         (idex_write),
        .exmem_write        (exmem_write),
        .ifid_flush         (ifid_flush),
        .idex_flush         (idex_flush),
        .memwb_bubble       (memwb_bubble),
        .mem_timeout        (mem_timeout),
        .stall_cycles       (stall_cycles),
        .flush_count        (flush_count)
    );

    // control vector packed as {pc,ifid_w,idex_w,exmem_w,ifid_f,idex_f,bubble}
    function automatic logic [6:0] ctl();
        return {pc_write, ifid_write, idex_write, exmem_write, ifid_flush, idex_flush, memwb_bubble};
    endfunction

    task automatic idle();
        idex_MemRead = 0; idex_writeRegister = 0;
        ifid_readRegister1 = 0; ifid_readRegister2 = 0;
        ifid_usesRs1 = 0; ifid_usesRs2 = 0; ifid_isStore = 0;
        ex_branchTaken = 0; exmem_memAccess = 0; dmem_ready = 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        idle();
        rst_n = 0;
        #3;
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        idle();
        ex_branchTaken = 1;
        rst_n = 0;
        #2;
        tests++;
        if (ctl() !== 7'b0000000 || stall_cycles !== 2'd0 || flush_count !== 2'd0 || mem_timeout !== 1'b0) begin
            fails++;
            $display("FAIL reset_state: ctl=%b stall=%0d flush=%0d to=%b, want ctl=0000000 0 0 0", ctl(), stall_cycles, flush_count, mem_timeout);
        end
        rst_n = 1;
        ex_branchTaken = 0;
        #1;
        tests++;
        if (ctl() !== 7'b1111000) begin
            fails++;
            $display("FAIL reset_release_run: ctl=%b want 1111000", ctl());
        end
        tick();
    endtask

    task automatic test_load_use();
        doReset();
        idex_MemRead = 1; idex_writeRegister = 5; ifid_readRegister1 = 5; ifid_usesRs1 = 1;
        #1;
        tests++;
        if (ctl() !== 7'b0011010) begin
            fails++;
            $display("FAIL load_use_rs1: ctl=%b want 0011010", ctl());
        end
        tick();
        idex_MemRead = 0;
        #1;
        tests++;
        if (ctl() !== 7'b1111000 || stall_cycles !== 2'd1) begin
            fails++;
            $display("FAIL load_use_after: ctl=%b stall=%0d want 1111000 1", ctl(), stall_cycles);
        end
    endtask

    task automatic test_store_rs2();
        doReset();
        idex_MemRead = 1; idex_writeRegister = 7; ifid_readRegister2 = 7; ifid_usesRs2 = 1; ifid_isStore = 1;
        #1;
        tests++;
        if (ctl() !== 7'b1111000) begin
            fails++;
            $display("FAIL store_rs2_nostall: ctl=%b want 1111000", ctl());
        end
        ifid_isStore = 0;
        #1;
        tests++;
        if (ctl() !== 7'b0011010) begin
            fails++;
            $display("FAIL nonstore_rs2_stall: ctl=%b want 0011010", ctl());
        end
        ifid_isStore = 1; ifid_usesRs1 = 1; ifid_readRegister1 = 7;
        #1;
        tests++;
        if (ctl() !== 7'b0011010) begin
            fails++;
            $display("FAIL store_rs1_stall: ctl=%b want 0011010", ctl());
        end
        idex_writeRegister = 0; ifid_readRegister1 = 0; ifid_readRegister2 = 0; ifid_isStore = 0;
        #1;
        tests++;
        if (ctl() !== 7'b1111000) begin
            fails++;
            $display("FAIL x0_nostall: ctl=%b want 1111000", ctl());
        end
        tick();
        tests++;
        if (stall_cycles !== 2'd0) begin
            fails++;
            $display("FAIL x0_stall_count: got %0d want 0", stall_cycles);
        end
    endtask

    task automatic test_branch_lu();
        doReset();
        idex_MemRead = 1; idex_writeRegister = 3; ifid_readRegister1 = 3; ifid_usesRs1 = 1; ex_branchTaken = 1;
        #1;
        tests++;
        if (ctl() !== 7'b1111110) begin
            fails++;
            $display("FAIL branch_over_lu: ctl=%b want 1111110", ctl());
        end
        tick();
        idle();
        #1;
        tests++;
        if (flush_count !== 2'd1 || stall_cycles !== 2'd0) begin
            fails++;
            $display("FAIL branch_counters: flush=%0d stall=%0d want 1 0", flush_count, stall_cycles);
        end
    endtask

    task automatic test_mem_wait();
        doReset();
        exmem_memAccess = 1; dmem_ready = 0;
        for (int i = 0; i < 3; i++) begin
            ex_branchTaken = (i == 1);
            idex_MemRead = (i == 2); idex_writeRegister = 4; ifid_readRegister1 = 4; ifid_usesRs1 = 1;
            #1;
            tests++;
            if (ctl() !== 7'b0000001) begin
                fails++;
                $display("FAIL mem_wait_cycle%0d: ctl=%b want 0000001", i, ctl());
            end
            tick();
        end
        idle();
        exmem_memAccess = 1; dmem_ready = 1;
        #1;
        tests++;
        if (ctl() !== 7'b1111000 || stall_cycles !== 2'd3 || mem_timeout !== 1'b0) begin
            fails++;
            $display("FAIL mem_wait_release: ctl=%b stall=%0d to=%b want 1111000 3 0", ctl(), stall_cycles, mem_timeout);
        end
        tick();
        dmem_ready = 0;
        for (int i = 0; i < 3; i++) tick();
        dmem_ready = 1;
        #1;
        tests++;
        if (mem_timeout !== 1'b0 || ctl() !== 7'b1111000 || stall_cycles !== 2'd3) begin
            fails++;
            $display("FAIL wait_counter_cleared: to=%b ctl=%b stall=%0d want 0 1111000 3", mem_timeout, ctl(), stall_cycles);
        end
        tick();
    endtask

    task automatic test_timeout();
        doReset();
        exmem_memAccess = 1; dmem_ready = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++;
            if (mem_timeout !== (i == 4)) begin
                fails++;
                $display("FAIL timeout_edge%0d: got %b want %b", i, mem_timeout, (i == 4));
            end
        end
        exmem_memAccess = 0; ex_branchTaken = 1;
        tick();
        tests++;
        if (ctl() !== 7'b0000000 || mem_timeout !== 1'b1) begin
            fails++;
            $display("FAIL error_hold: ctl=%b to=%b want 0000000 1", ctl(), mem_timeout);
        end
        #2;
        rst_n = 0;
        #1;
        tests++;
        if (mem_timeout !== 1'b0 || ctl() !== 7'b0000000) begin
            fails++;
            $display("FAIL error_async_reset: to=%b ctl=%b want 0 0000000", mem_timeout, ctl());
        end
        rst_n = 1;
        ex_branchTaken = 0;
        #1;
        tests++;
        if (ctl() !== 7'b1111000) begin
            fails++;
            $display("FAIL error_reset_run: ctl=%b want 1111000", ctl());
        end
        tick();
    endtask

    task automatic test_saturation();
        doReset();
        ex_branchTaken = 1;
        for (int i = 1; i <= 5; i++) begin
            tick();
            tests++;
            if (flush_count !== 2'((i > 3) ? 3 : i)) begin
                fails++;
                $display("FAIL flush_sat%0d: got %0d want %0d", i, flush_count, (i > 3) ? 3 : i);
            end
        end
        idle();
    endtask

    initial begin
        idle();
        rst_n = 1;
        #1;
        test_reset();
        test_load_use();
        test_store_rs2();
        test_branch_lu();
        test_mem_wait();
        test_timeout();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
